// File: rtl/fir_output_stage.sv
// FIR output stage: captures the accumulator on each sample strobe, rounds and
// saturates it, and buffers the result in a show-ahead FIFO behind a valid/ready port.
module fir_output_stage #(
  parameter int ACC_W      = 20,
  parameter int OUT_W      = 8,
  parameter int FRAC_SHIFT = 8,
  parameter int DEPTH      = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [ACC_W-1:0]        acc_in,
  input  logic                           sample_en,
  input  logic                           clear_flags,
  output logic signed [OUT_W-1:0]        out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           overflow,
  output logic                           sat_flag
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic signed [ACC_W:0] RND     = {{ACC_W{1'b0}}, 1'b1} << (FRAC_SHIFT-1);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W:0] ext;
    ext = {x[ACC_W-1], x};
    return (ext + RND) >>> FRAC_SHIFT;
  endfunction

  function automatic logic is_sat(input logic signed [ACC_W:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] v);
    if (v > SAT_MAX)
      return SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[OUT_W-1:0];
    else
      return v[OUT_W-1:0];
  endfunction

  logic signed [ACC_W:0]   q_ext_p0;
  logic                    sat_p0;
  logic signed [OUT_W-1:0] data_p1;
  logic                    vld_p1;

  logic signed [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    full;
  logic                    pop;
  logic                    wr_en;
  logic                    drop;

  // Stage 0 -> 1: round, saturate and capture on the strobe
  assign q_ext_p0 = round_shift(acc_in);
  assign sat_p0   = sample_en && is_sat(q_ext_p0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= sample_en;
  end

  always_ff @(posedge clk) begin
    if (sample_en)
      data_p1 <= saturate(q_ext_p0);
  end

  // Stage 1 -> 2: FIFO push; a pop on the same edge frees the slot when full
  assign full     = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign pop      = out_valid && out_ready;
  assign wr_en    = vld_p1 && (!full || pop);
  assign drop     = vld_p1 && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= data_p1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (drop)
        overflow <= 1'b1;
      else if (clear_flags)
        overflow <= 1'b0;
      if (sat_p0)
        sat_flag <= 1'b1;
      else if (clear_flags)
        sat_flag <= 1'b0;
    end
  end

  assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule
